ocp_slave_mem: RTL and testbench

- OCP slave memory model sitting directly downstream of the AXI-to-OCP interconnect; consumes its OCP master port.
- Accepts single-word reads and writes, stores writes in an internal word array, and returns read data after a fixed latency through a response FIFO with MRespAccept back-pressure.
- Flags out-of-range accesses with an OCP ERR response and a saturating error counter.

---
 rtl/ocp_slave_mem.sv | 206 ++++++++++++++++++++
 tb/tb_ocp_slave_mem.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ocp_slave_mem.sv
// OCP slave memory: single-word posted writes, fixed-latency reads through an
// in-order response FIFO with MRespAccept back-pressure and error counting.
module ocp_slave_mem #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    MCmd,
  input  logic [AW-1:0] MAddr,
  input  logic [3:0]    MTagID,
  input  logic [DW-1:0] Mdata,
  input  logic          MDataValid,
  input  logic          MRespAccept,
  output logic          SCmdAccept,
  output logic          SDataAccept,
  output logic [1:0]    SResp,
  output logic [DW-1:0] Sdata,
  output logic [3:0]    STagID,
  output logic [7:0]    err_count
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned RW = $clog2(RESP_DEPTH);
  localparam int unsigned CW = RW + 1;

  localparam logic [2:0] CMD_WR = 3'd1;
  localparam logic [2:0] CMD_RD = 3'd2;
  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  typedef enum logic {W_IDLE, W_WAIT_DATA} wstate_t;

  wstate_t wstate_q, wstate_d;

  logic [DW-1:0] mem [DEPTH];

  logic          cmd_wr, cmd_rd, addr_ok;
  logic [IW-1:0] addr_idx;

  logic [IW-1:0] lat_idx;
  logic          lat_ok, lat_en;

  logic          wr_en, rd_acc, err_inc;
  logic [IW-1:0] wr_idx;

  logic [RD_LAT-1:0] pipe_v;
  logic [3:0]        pipe_tag  [RD_LAT];
  logic [DW-1:0]     pipe_data [RD_LAT];
  logic              pipe_err  [RD_LAT];

  logic [CW-1:0] wr_ptr, rd_ptr, fifo_cnt;
  logic [3:0]    fifo_tag  [RESP_DEPTH];
  logic [DW-1:0] fifo_data [RESP_DEPTH];
  logic          fifo_err  [RESP_DEPTH];
  logic          fifo_empty, push, pop;
  logic [31:0]   resv;

  assign cmd_wr   = (MCmd == CMD_WR);
  assign cmd_rd   = (MCmd == CMD_RD);
  assign addr_ok  = (MAddr[1:0] == 2'b00) && (MAddr[AW-1:2+IW] == '0);
  assign addr_idx = MAddr[2 +: IW];

  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = pipe_v[RD_LAT-1];
  assign pop        = !fifo_empty && MRespAccept;

  // Slots already promised to responses: queued plus still in the read pipeline.
  always_comb begin
    resv = 32'(fifo_cnt);
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      resv = resv + 32'(pipe_v[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q <= W_IDLE;
    end else begin
      wstate_q <= wstate_d;
    end
  end

  always_comb begin
    wstate_d    = wstate_q;
    SCmdAccept  = 1'b0;
    SDataAccept = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = addr_idx;
    lat_en      = 1'b0;
    rd_acc      = 1'b0;
    err_inc     = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        SCmdAccept = !rst && (resv < 32'(RESP_DEPTH));
        if (SCmdAccept && cmd_wr) begin
          if (MDataValid) begin
            SDataAccept = 1'b1;
            wr_en       = addr_ok;
            err_inc     = !addr_ok;
          end else begin
            lat_en   = 1'b1;
            wstate_d = W_WAIT_DATA;
          end
        end
        if (SCmdAccept && cmd_rd) begin
          rd_acc  = 1'b1;
          err_inc = !addr_ok;
        end
      end
      W_WAIT_DATA: begin
        if (MDataValid && !rst) begin
          SDataAccept = 1'b1;
          wr_idx      = lat_idx;
          wr_en       = lat_ok;
          err_inc     = !lat_ok;
          wstate_d    = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_idx <= '0;
      lat_ok  <= 1'b0;
    end else if (lat_en) begin
      lat_idx <= addr_idx;
      lat_ok  <= addr_ok;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= Mdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= rd_acc;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
      end
    end
  end

  // Read data is captured at accept, so a same-edge write is not observed.
  always_ff @(posedge clk) begin
    pipe_tag[0]  <= MTagID;
    pipe_data[0] <= addr_ok ? mem[addr_idx] : '0;
    pipe_err[0]  <= !addr_ok;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pipe_tag[i]  <= pipe_tag[i-1];
      pipe_data[i] <= pipe_data[i-1];
      pipe_err[i]  <= pipe_err[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_tag[wr_ptr[RW-1:0]]  <= pipe_tag[RD_LAT-1];
      fifo_data[wr_ptr[RW-1:0]] <= pipe_data[RD_LAT-1];
      fifo_err[wr_ptr[RW-1:0]]  <= pipe_err[RD_LAT-1];
    end
  end

  always_comb begin
    SResp  = RESP_NULL;
    Sdata  = '0;
    STagID = '0;
    if (!fifo_empty) begin
      SResp  = fifo_err[rd_ptr[RW-1:0]] ? RESP_ERR : RESP_DVA;
      Sdata  = fifo_data[rd_ptr[RW-1:0]];
      STagID = fifo_tag[rd_ptr[RW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_inc && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Scoreboard bench for ocp_slave_mem: directed commands push expected
// responses; a monitor pops and compares on every accepted response.
module tb_ocp_slave_mem;

  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned RESP_DEPTH = 4;
  localparam logic [2:0] C_IDLE = 3'd0;
  localparam logic [2:0] C_WR   = 3'd1;
  localparam logic [2:0] C_RD   = 3'd2;
  localparam logic [1:0] R_NULL = 2'd0;
  localparam logic [1:0] R_DVA  = 2'd1;
  localparam logic [1:0] R_ERR  = 2'd3;

  logic        clk, rst;
  logic [2:0]  MCmd;
  logic [31:0] MAddr;
  logic [3:0]  MTagID;
  logic [31:0] Mdata;
  logic        MDataValid, MRespAccept;
  logic        SCmdAccept, SDataAccept;
  logic [1:0]  SResp;
  logic [31:0] Sdata;
  logic [3:0]  STagID;
  logic [7:0]  err_count;

  typedef struct packed {
    logic [1:0]  resp;
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  ocp_slave_mem #(
    .AW(32), .DW(32), .DEPTH(256), .RD_LAT(RD_LAT), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .MCmd(MCmd), .MAddr(MAddr), .MTagID(MTagID),
    .Mdata(Mdata), .MDataValid(MDataValid), .MRespAccept(MRespAccept),
    .SCmdAccept(SCmdAccept), .SDataAccept(SDataAccept), .SResp(SResp),
    .Sdata(Sdata), .STagID(STagID), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every response taken by the master must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && SResp != R_NULL && MRespAccept) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {SResp, STagID, Sdata}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp", {SResp, STagID, Sdata}, {e.resp, e.tag, e.data});
      end
    end
  end

  task automatic do_cmd(input logic [2:0] cmd, input logic [31:0] addr, input logic [3:0] tag,
                        input logic [31:0] data, input logic dv, input bit push,
                        input logic [1:0] eresp, input logic [31:0] edata, output logic da);
    logic ok;
    ok = 1'b0;
    da = 1'b0;
    MCmd = cmd; MAddr = addr; MTagID = tag; Mdata = data; MDataValid = dv;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (SCmdAccept) begin
        ok = 1'b1;
        da = SDataAccept;
      end
      @(posedge clk);
    end
    if (ok && push) exp_q.push_back('{resp: eresp, tag: tag, data: edata});
    #1;
    MCmd = C_IDLE; MDataValid = 1'b0;
    chk("cmd_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // One cycle of a back-to-back read stream; idx advances on accept.
  task automatic rd_step(inout int idx, input int total, input logic [31:0] edata);
    logic acc;
    @(negedge clk);
    acc = SCmdAccept;
    @(posedge clk);
    if (acc && idx < total) begin
      exp_q.push_back('{resp: R_DVA, tag: 4'(idx), data: edata});
      idx++;
    end
    #1;
    if (idx < total) MTagID = 4'(idx);
    else MCmd = C_IDLE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic da;
    int   idx;
    rst = 1'b1; MCmd = C_IDLE; MAddr = '0; MTagID = '0; Mdata = '0;
    MDataValid = 1'b0; MRespAccept = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_SCmdAccept", 64'(SCmdAccept), 64'd0);
    chk("rst_SDataAccept", 64'(SDataAccept), 64'd0);
    chk("rst_SResp", 64'(SResp), 64'(R_NULL));
    chk("rst_Sdata_tag", {STagID, Sdata}, 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    rst = 1'b0;

    // Reset while a read is in flight
    do_cmd(C_RD, 32'h401, 4'd3, 32'h0, 1'b0, 1'b1, R_ERR, 32'h0, da);
    drain();
    chk("err_before_rst", 64'(err_count), 64'd1);
    do_cmd(C_RD, 32'h0, 4'd7, 32'h0, 1'b0, 1'b0, R_NULL, 32'h0, da);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {SCmdAccept, SDataAccept, SResp, STagID, Sdata, err_count}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < RD_LAT + 2; c++) begin
      @(negedge clk);
      chk("no_stale_resp", 64'(SResp), 64'(R_NULL));
    end
    @(posedge clk);
    #1;

    // Immediate write then read with exact latency
    do_cmd(C_WR, 32'h10, 4'd0, 32'hDEADBEEF, 1'b1, 1'b0, R_NULL, 32'h0, da);
    chk("wr_same_cycle_data_accept", 64'(da), 64'd1);
    do_cmd(C_RD, 32'h10, 4'd5, 32'h0, 1'b0, 1'b1, R_DVA, 32'hDEADBEEF, da);
    repeat (RD_LAT) @(negedge clk);
    chk("lat_early", 64'(SResp), 64'(R_NULL));
    @(negedge clk);
    chk("lat_exact", {SResp, STagID, Sdata}, {R_DVA, 4'd5, 32'hDEADBEEF});
    @(negedge clk);
    chk("lat_held_one", 64'(SResp), 64'(R_NULL));
    @(posedge clk);
    #1;

    // Write with data arriving later; next command must wait
    do_cmd(C_WR, 32'h20, 4'd0, 32'h0, 1'b0, 1'b0, R_NULL, 32'h0, da);
    chk("wr_late_no_data_accept", 64'(da), 64'd0);
    MCmd = C_RD; MAddr = 32'h20; MTagID = 4'd6;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("wait_data_cmd_blocked", {SCmdAccept, SDataAccept}, 64'd0);
      @(posedge clk);
      #1;
    end
    Mdata = 32'hCAFEF00D; MDataValid = 1'b1;
    @(negedge clk);
    chk("late_data_accept", {SCmdAccept, SDataAccept}, 64'd1);
    @(posedge clk);
    #1;
    MDataValid = 1'b0;
    do_cmd(C_RD, 32'h20, 4'd6, 32'h0, 1'b0, 1'b1, R_DVA, 32'hCAFEF00D, da);
    drain();

    // Back-pressure: only RESP_DEPTH reads accepted while responses are stalled
    MRespAccept = 1'b0;
    idx = 0;
    MCmd = C_RD; MAddr = 32'h10; MTagID = 4'd0;
    for (int c = 0; c < 12; c++) rd_step(idx, 6, 32'hDEADBEEF);
    chk("accepted_while_stalled", 64'(idx), 64'(RESP_DEPTH));
    @(negedge clk);
    chk("stalled_cmd_accept", 64'(SCmdAccept), 64'd0);
    @(posedge clk);
    #1;
    MRespAccept = 1'b1;
    for (int c = 0; c < 40 && idx < 6; c++) rd_step(idx, 6, 32'hDEADBEEF);
    chk("accepted_after_release", 64'(idx), 64'd6);
    MCmd = C_IDLE;
    drain();

    // Out-of-range reads and write
    do_cmd(C_WR, 32'h0, 4'd0, 32'hA5A5A5A5, 1'b1, 1'b0, R_NULL, 32'h0, da);
    do_cmd(C_RD, 32'h400, 4'd1, 32'h0, 1'b0, 1'b1, R_ERR, 32'h0, da);
    do_cmd(C_RD, 32'h13, 4'd2, 32'h0, 1'b0, 1'b1, R_ERR, 32'h0, da);
    drain();
    chk("err_count_2", 64'(err_count), 64'd2);
    do_cmd(C_WR, 32'h400, 4'd0, 32'h12345678, 1'b1, 1'b0, R_NULL, 32'h0, da);
    chk("bad_wr_data_accept", 64'(da), 64'd1);
    chk("err_count_3", 64'(err_count), 64'd3);
    do_cmd(C_RD, 32'h0, 4'd3, 32'h0, 1'b0, 1'b1, R_DVA, 32'hA5A5A5A5, da);
    drain();

    // FIFO near full with simultaneous push/pop, then saturate err_count
    MRespAccept = 1'b0;
    for (int t = 8; t < 11; t++)
      do_cmd(C_RD, 32'h10, 4'(t), 32'h0, 1'b0, 1'b1, R_DVA, 32'hDEADBEEF, da);
    repeat (RD_LAT + 1) @(posedge clk);
    #1;
    MRespAccept = 1'b1;
    for (int t = 0; t < 8; t++)
      do_cmd(C_RD, 32'h20, 4'(t), 32'h0, 1'b0, 1'b1, R_DVA, 32'hCAFEF00D, da);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = (i % 2 == 1) ? 32'h13 : 32'h400 + 32'(i) * 32'd4;
      MRespAccept = (i % 4 != 3);
      do_cmd(C_RD, a, 4'(i), 32'h0, 1'b0, 1'b1, R_ERR, 32'h0, da);
      if (i == 250) chk("err_count_fe", 64'(err_count), 64'hFE);
    end
    chk("err_count_sat", 64'(err_count), 64'hFF);
    MRespAccept = 1'b1;
    drain();
    @(negedge clk);
    chk("final_idle", 64'(SResp), 64'(R_NULL));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
